// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// It uses radix-2 shift-add multiply and restoring divide on operand magnitudes, then a sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   srca_q, srca_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               zdiv_q, zdiv_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic               idle;
   logic               accept;
   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign idle   = (state_q == S_IDLE);
   assign accept = idle & start & ~op[2];

   // Signs only matter for the signed ops (op[0]=1); unsigned ops see raw values.
   assign sa    = srca[WIDTH-1] & op[0];
   assign sb    = srcb[WIDTH-1] & op[0];
   assign mag_a = sa ? -srca : srca;
   assign mag_b = sb ? -srcb : srcb;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   // Partial remainder after the left shift needs WIDTH+1 bits, plus one for the borrow.
   assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};

   assign prod = neg_q  ? -acc_q                   : acc_q;
   assign quo  = neg_q  ? -acc_q[WIDTH-1:0]        : acc_q[WIDTH-1:0];
   assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]  : acc_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = op[1] ? S_DIV : S_MUL;
         S_MUL,
         S_DIV:   if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall = busy_q | accept;
   end

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      srca_d     = srca_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      zdiv_d     = zdiv_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
               opb_d      = op[1] ? mag_b : mag_a;
               srca_d     = srca;
               cnt_d      = CNTW'(WIDTH);
               is_div_d   = op[1];
               neg_d      = sa ^ sb;
               rneg_d     = sa;
               zdiv_d     = (srcb == '0);
               busy_d     = 1'b1;
               div_zero_d = 1'b0;
            end else if (start && op[2] && !op[1]) begin
               if (op[0]) lo_d = srca;
               else       hi_d = srca;
            end
         end
         S_MUL: begin
            if (cnt_q != '0) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_DIV: begin
            if (cnt_q != '0) begin
               if (div_diff[WIDTH+1]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
               else                   acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_FIX: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (!is_div_q) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (zdiv_q) begin
               // Zero divisor: report the dividend untouched rather than the sign-fixed remainder.
               lo_d       = '1;
               hi_d       = srca_q;
               div_zero_d = 1'b1;
            end else begin
               lo_d = quo;
               hi_d = rem;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         srca_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         zdiv_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         srca_q     <= srca_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         zdiv_q     <= zdiv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for MTHI/MTLO, busy-start, reset and WIDTH=8.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srca, srcb;
   logic        stall, busy, done, div_zero;
   logic [31:0] hi, lo;

   logic        start8;
   logic [2:0]  op8;
   logic [7:0]  srca8, srcb8;
   logic        stall8, busy8, done8, div_zero8;
   logic [7:0]  hi8, lo8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .stall(stall), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(srca8), .srcb(srcb8),
      .stall(stall8), .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0; l = '0; dz = 1'b0;
      case (o)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
         3'd1: begin q = sa * sb; p = q; h = p[63:32]; l = p[31:0]; end
         3'd2: begin
            if (b == 0) begin dz = 1'b1; l = '1; h = a; end
            else begin l = a / b; h = a % b; end
         end
         3'd3: begin
            if (b == 0) begin dz = 1'b1; l = '1; h = a; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issues one mul/div; optionally pokes start (MTHI, then DIVU) while busy at lat==inj.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output int bcnt,
                         output logic dz0, output logic st0, output logic done_again);
      @(negedge clk);
      start = 1'b1; op = o; srca = a; srcb = b;
      #1 st0 = stall;
      @(negedge clk);
      start = 1'b0; lat = 0; bcnt = 0; dz0 = div_zero;
      while (!done && lat < 200) begin
         if (busy) bcnt++;
         if (lat == inj) begin
            start = 1'b1; op = 3'b100; srca = 32'hDEAD_BEEF;
         end else if (lat == inj + 1) begin
            op = 3'b010; srca = 32'h1; srcb = 32'h1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      @(negedge clk);
      done_again = done;
   endtask

   initial begin
      int          lat, bcnt;
      logic        dz0, st0, dagain, seen;
      logic [2:0]  ro;
      logic [31:0] ra, rb, eh, el;
      logic        edz;

      tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[1] = '{3'd1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
      tbl[2] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      tbl[3] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[4] = '{3'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      tbl[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[6] = '{3'd2, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      tbl[7] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

      reset = 1'b0; start = 1'b0; op = '0; srca = '0; srcb = '0;
      start8 = 1'b0; op8 = '0; srca8 = '0; srcb8 = '0;
      #12;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.div_zero", div_zero, 0);
      chk("rst.hi", hi, 0);
      chk("rst.lo", lo, 0);
      chk("rst.stall", stall, 0);
      chk("rst.busy8", busy8, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1000, lat, bcnt, dz0, st0, dagain);
         chk($sformatf("vec%0d.stall_at_accept", i), st0, 1);
         chk($sformatf("vec%0d.latency", i), lat, 34);
         chk($sformatf("vec%0d.busy_cycles", i), bcnt, 34);
         chk($sformatf("vec%0d.hi", i), hi, tbl[i].hi);
         chk($sformatf("vec%0d.lo", i), lo, tbl[i].lo);
         chk($sformatf("vec%0d.div_zero", i), div_zero, tbl[i].dz);
         chk($sformatf("vec%0d.dz_cleared_on_accept", i), dz0, 0);
         chk($sformatf("vec%0d.done_one_cycle", i), dagain, 0);
         $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d",
                  i, tbl[i].op, tbl[i].a, tbl[i].b, hi, lo, div_zero, lat);
      end

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         model(ro, ra, rb, eh, el, edz);
         run_op(ro, ra, rb, 1000, lat, bcnt, dz0, st0, dagain);
         chk($sformatf("rnd%0d.latency", i), lat, 34);
         chk($sformatf("rnd%0d.hi", i), hi, eh);
         chk($sformatf("rnd%0d.lo", i), lo, el);
         chk($sformatf("rnd%0d.div_zero", i), div_zero, edz);
         $display("rnd %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b", i, ro, ra, rb, hi, lo, div_zero);
      end

      // MTHI then MTLO back to back, then a no-op start.
      @(negedge clk);
      start = 1'b1; op = 3'b100; srca = 32'hA5A5_A5A5;
      #1 chk("mthi.stall", stall, 0);
      @(negedge clk);
      chk("mthi.hi", hi, 32'hA5A5_A5A5);
      op = 3'b101; srca = 32'h5A5A_5A5A;
      #1 chk("mtlo.stall", stall, 0);
      @(negedge clk);
      chk("mtlo.lo", lo, 32'h5A5A_5A5A);
      chk("mtlo.hi_held", hi, 32'hA5A5_A5A5);
      chk("mt.busy", busy, 0);
      chk("mt.done", done, 0);
      op = 3'b110; srca = 32'h0;
      #1 chk("nop.stall", stall, 0);
      @(negedge clk);
      start = 1'b0;
      chk("nop.hi", hi, 32'hA5A5_A5A5);
      chk("nop.lo", lo, 32'h5A5A_5A5A);
      $display("mt: hi=%h lo=%h", hi, lo);

      // Start requests while a MULT runs must be ignored.
      run_op(3'd1, 32'hFFFF_FFF9, 32'h6, 5, lat, bcnt, dz0, st0, dagain);
      chk("busystart.latency", lat, 34);
      chk("busystart.hi", hi, 32'hFFFF_FFFF);
      chk("busystart.lo", lo, 32'hFFFF_FFD6);
      $display("busystart: hi=%h lo=%h lat=%0d", hi, lo, lat);

      // Asynchronous reset in the middle of a DIV.
      @(negedge clk);
      start = 1'b1; op = 3'd3; srca = 32'hFFFF_FFF9; srcb = 32'h2;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrst.busy_before", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.hi", hi, 0);
      chk("midrst.lo", lo, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("midrst.no_done", seen, 0);
      chk("midrst.hi_after", hi, 0);
      chk("midrst.lo_after", lo, 0);
      $display("midrst: hi=%h lo=%h busy=%0b", hi, lo, busy);

      // WIDTH=8 instance: MULT -128*-128 and DIV -128/-1.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start8 = 1'b1;
         op8    = (k == 0) ? 3'd1 : 3'd3;
         srca8  = 8'h80;
         srcb8  = (k == 0) ? 8'h80 : 8'hFF;
         @(negedge clk);
         start8 = 1'b0;
         lat = 0;
         while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("w8_%0d.latency", k), lat, 10);
         chk($sformatf("w8_%0d.hi", k), hi8, (k == 0) ? 8'h40 : 8'h00);
         chk($sformatf("w8_%0d.lo", k), lo8, (k == 0) ? 8'h00 : 8'h80);
         $display("w8 %0d: hi=%h lo=%h lat=%0d", k, hi8, lo8, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
